// File: rtl/formula_dispatch_pkg.sv
// Shared definitions for the formula task dispatcher.
//   FORMULA_1 / FORMULA_2 : formula selector values
//   word_t                : 32-bit unsigned argument / result word
//   worker_idx_w(n)       : width of a pointer that indexes n workers (minimum 1)
package formula_dispatch_pkg;

  localparam int FORMULA_1 = 1;
  localparam int FORMULA_2 = 2;

  typedef logic [31:0] word_t;

  function automatic int worker_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/formula_worker_slot.sv
// One worker slot: an iterative isqrt-based formula engine plus the slot's
// busy/done flags and result hold register.
//   clk, rst  : clock, synchronous active-high reset
//   dispatch  : one-cycle start pulse carrying a, b, c
//   pop       : consumer has taken this slot's held result
//   busy      : slot owns an accepted, not yet popped triple
//   done      : hold contains this slot's finished result
//   hold      : finished result
module formula_worker_slot
  import formula_dispatch_pkg::*;
#(
  parameter int FORMULA = FORMULA_1,
  parameter int IMPL    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dispatch,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic        pop,
  output logic        busy,
  output logic        done,
  output logic [31:0] hold
);

  // Both formula-1 variants yield identical results; one engine serves both.
  if (FORMULA == FORMULA_1 && IMPL != 1 && IMPL != 2) begin : g_bad_impl
    $error("formula_worker_slot: IMPL must be 1 or 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_SQRT, S_NEXT} state_t;

  // 34-bit operands cover b+isqrt(c) and a+isqrt(...) without overflow.
  localparam logic [33:0] BIT_START = 34'h100000000;

  state_t      state;
  word_t       op_a, op_b;
  logic [1:0]  phase;
  logic [4:0]  iter;
  logic [33:0] rem, root, bitv, acc;
  logic [33:0] trial;
  logic        wvld;
  word_t       wres;

  assign trial = root + bitv;

  // Three bit-serial square roots in sequence (c, then b, then a), 17 steps
  // each; between roots the next operand is formed from the previous root.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      wvld  <= 1'b0;
      wres  <= '0;
      op_a  <= '0;
      op_b  <= '0;
      phase <= '0;
      iter  <= '0;
      rem   <= '0;
      root  <= '0;
      bitv  <= '0;
      acc   <= '0;
    end else begin
      wvld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dispatch) begin
            op_a  <= a;
            op_b  <= b;
            rem   <= {2'b00, c};
            root  <= '0;
            bitv  <= BIT_START;
            iter  <= '0;
            phase <= '0;
            acc   <= '0;
            state <= S_SQRT;
          end
        end
        S_SQRT: begin
          if (rem >= trial) begin
            rem  <= rem - trial;
            root <= (root >> 1) + bitv;
          end else begin
            root <= root >> 1;
          end
          bitv <= bitv >> 2;
          iter <= iter + 5'd1;
          if (iter == 5'd16) state <= S_NEXT;
        end
        S_NEXT: begin
          root  <= '0;
          bitv  <= BIT_START;
          iter  <= '0;
          phase <= phase + 2'd1;
          state <= S_SQRT;
          case (phase)
            2'd0: begin
              if (FORMULA == FORMULA_1) begin
                acc <= root;
                rem <= {2'b00, op_b};
              end else begin
                rem <= {2'b00, op_b} + root;
              end
            end
            2'd1: begin
              if (FORMULA == FORMULA_1) begin
                acc <= acc + root;
                rem <= {2'b00, op_a};
              end else begin
                rem <= {2'b00, op_a} + root;
              end
            end
            default: begin
              wres  <= (FORMULA == FORMULA_1) ? 32'(acc + root) : root[31:0];
              wvld  <= 1'b1;
              state <= S_IDLE;
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A worker pulse for a slot that was never dispatched is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      hold <= '0;
    end else begin
      if (dispatch) busy <= 1'b1;
      if (pop) begin
        busy <= 1'b0;
        done <= 1'b0;
      end
      if (wvld && busy) begin
        hold <= wres;
        done <= 1'b1;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) wvld |-> busy);

endmodule

// File: rtl/formula_task_dispatcher.sv
// Round-robin dispatcher over N_WORKERS formula worker slots with valid/ready
// on both sides; results are returned strictly in argument-arrival order.
//   clk, rst          : clock, synchronous active-high reset (resets all slots)
//   arg_vld/arg_rdy   : argument triple handshake, a/b/c unsigned 32-bit
//   res_vld/res_rdy   : result handshake, res unsigned 32-bit (0 when idle)
//   inflight          : triples accepted and not yet popped
module formula_task_dispatcher
  import formula_dispatch_pkg::*;
#(
  parameter int FORMULA   = 1,
  parameter int IMPL      = 1,
  parameter int N_WORKERS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arg_vld,
  output logic                           arg_rdy,
  input  logic [31:0]                    a,
  input  logic [31:0]                    b,
  input  logic [31:0]                    c,
  output logic                           res_vld,
  input  logic                           res_rdy,
  output logic [31:0]                    res,
  output logic [$clog2(N_WORKERS+1)-1:0] inflight
);

  if (FORMULA != FORMULA_1 && FORMULA != FORMULA_2) begin : g_bad_formula
    $error("formula_task_dispatcher: FORMULA must be 1 or 2");
  end
  if (N_WORKERS < 1 || N_WORKERS > 64) begin : g_bad_n
    $error("formula_task_dispatcher: N_WORKERS must be 1..64");
  end

  localparam int IW = worker_idx_w(N_WORKERS);
  localparam int CW = $clog2(N_WORKERS+1);
  localparam logic [IW-1:0] LAST = IW'(N_WORKERS-1);

  logic [IW-1:0]  wr_ptr, rd_ptr;
  logic [N_WORKERS-1:0] busy, done;
  word_t          hold [N_WORKERS];
  logic           accept, pop;

  // Slots fill and drain in ring order, so the slot under wr_ptr being busy
  // means the ring is full.
  assign arg_rdy = !rst && !busy[wr_ptr];
  assign accept  = arg_vld && arg_rdy;
  assign res_vld = done[rd_ptr];
  assign res     = res_vld ? hold[rd_ptr] : '0;
  assign pop     = res_vld && res_rdy;

  for (genvar k = 0; k < N_WORKERS; k++) begin : g_slot
    formula_worker_slot #(.FORMULA(FORMULA), .IMPL(IMPL)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .dispatch (accept && (wr_ptr == IW'(k))),
      .a        (a),
      .b        (b),
      .c        (c),
      .pop      (pop && (rd_ptr == IW'(k))),
      .busy     (busy[k]),
      .done     (done[k]),
      .hold     (hold[k])
    );
  end

  // Ring pointers and the outstanding-triple count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (accept) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)    rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_formula_task_dispatcher.sv
// Self-checking bench for formula_task_dispatcher. Four instances cover
// FORMULA 1/2 and N_WORKERS 1/4/64; a queue-based reference model predicts
// every result and the in-order / occupancy / hold behaviour.
module tb_formula_task_dispatcher;

  logic        clk = 1'b0;
  logic        rst     [4];
  logic        arg_vld [4];
  logic        arg_rdy [4];
  logic [31:0] a       [4];
  logic [31:0] b       [4];
  logic [31:0] c       [4];
  logic        res_vld [4];
  logic        res_rdy [4];
  logic [31:0] res     [4];
  logic [6:0]  inflight[4];
  logic [2:0]  inf0, inf1;
  logic [0:0]  inf2;
  logic [6:0]  inf3;

  int nw [4] = '{4, 4, 1, 64};
  int ff [4] = '{1, 2, 1, 2};

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] expq [$];
  logic        held;
  logic [31:0] held_res;

  always #5 clk = ~clk;

  assign inflight[0] = {4'b0, inf0};
  assign inflight[1] = {4'b0, inf1};
  assign inflight[2] = {6'b0, inf2};
  assign inflight[3] = inf3;

  formula_task_dispatcher #(.FORMULA(1), .IMPL(1), .N_WORKERS(4)) u0 (
    .clk(clk), .rst(rst[0]), .arg_vld(arg_vld[0]), .arg_rdy(arg_rdy[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .res_vld(res_vld[0]), .res_rdy(res_rdy[0]),
    .res(res[0]), .inflight(inf0));
  formula_task_dispatcher #(.FORMULA(2), .IMPL(1), .N_WORKERS(4)) u1 (
    .clk(clk), .rst(rst[1]), .arg_vld(arg_vld[1]), .arg_rdy(arg_rdy[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .res_vld(res_vld[1]), .res_rdy(res_rdy[1]),
    .res(res[1]), .inflight(inf1));
  formula_task_dispatcher #(.FORMULA(1), .IMPL(2), .N_WORKERS(1)) u2 (
    .clk(clk), .rst(rst[2]), .arg_vld(arg_vld[2]), .arg_rdy(arg_rdy[2]),
    .a(a[2]), .b(b[2]), .c(c[2]), .res_vld(res_vld[2]), .res_rdy(res_rdy[2]),
    .res(res[2]), .inflight(inf2));
  formula_task_dispatcher #(.FORMULA(2), .IMPL(1), .N_WORKERS(64)) u3 (
    .clk(clk), .rst(rst[3]), .arg_vld(arg_vld[3]), .arg_rdy(arg_rdy[3]),
    .a(a[3]), .b(b[3]), .c(c[3]), .res_vld(res_vld[3]), .res_rdy(res_rdy[3]),
    .res(res[3]), .inflight(inf3));

  // Largest r with r*r <= v, found by setting bits from the top down.
  function automatic longint unsigned isq(input longint unsigned v);
    longint unsigned r, t;
    r = 0;
    for (int bitn = 17; bitn >= 0; bitn--) begin
      t = r | (64'd1 << bitn);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  function automatic logic [31:0] model(input int f, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [31:0] cv);
    longint unsigned x;
    if (f == 1) return 32'(isq({32'b0, av}) + isq({32'b0, bv}) + isq({32'b0, cv}));
    x = {32'b0, bv} + isq({32'b0, cv});
    x = {32'b0, av} + isq(x);
    return 32'(isq(x));
  endfunction

  function automatic logic [31:0] rnd();
    return ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 5000);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle on DUT k, entered and left at a falling edge.
  task automatic cycle(input int k, input logic vld, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] cv,
                       input logic rrdy, output logic accepted);
    logic popped;
    arg_vld[k] = vld; a[k] = av; b[k] = bv; c[k] = cv; res_rdy[k] = rrdy;
    #1;
    check("inflight", 64'(inflight[k]), 64'(expq.size()));
    check("arg_rdy", 64'(arg_rdy[k]), 64'(expq.size() < nw[k]));
    if (!res_vld[k]) check("res_idle_zero", 64'(res[k]), 64'd0);
    if (held) begin
      check("hold_vld", 64'(res_vld[k]), 64'd1);
      check("hold_res", 64'(res[k]), 64'(held_res));
    end
    accepted = vld && arg_rdy[k];
    popped   = res_vld[k] && rrdy;
    if (popped) begin
      if (expq.size() == 0) check("spurious_vld", 64'(res_vld[k]), 64'd0);
      else check("result", 64'(res[k]), 64'(expq.pop_front()));
    end
    held     = res_vld[k] && !rrdy;
    held_res = res[k];
    if (accepted) expq.push_back(model(ff[k], av, bv, cv));
    @(negedge clk);
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1; arg_vld[k] = 1'b0; res_rdy[k] = 1'b0;
    #1;
    check("rdy_in_rst", 64'(arg_rdy[k]), 64'd0);
    @(negedge clk);
    rst[k] = 1'b0;
    expq.delete();
    held = 1'b0;
    #1;
    check("rst_res_vld", 64'(res_vld[k]), 64'd0);
    check("rst_res", 64'(res[k]), 64'd0);
    check("rst_inflight", 64'(inflight[k]), 64'd0);
    check("rst_arg_rdy", 64'(arg_rdy[k]), 64'd1);
  endtask

  task automatic send(input int k, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] cv, input logic rrdy);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 500 && !acc; n++) cycle(k, 1'b1, av, bv, cv, rrdy, acc);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int k, input int ncyc, input logic rrdy);
    logic acc;
    for (int n = 0; n < ncyc; n++) cycle(k, 1'b0, '0, '0, '0, rrdy, acc);
  endtask

  task automatic drain(input int k);
    logic acc;
    for (int n = 0; n < 5000 && expq.size() > 0; n++) cycle(k, 1'b0, '0, '0, '0, 1'b1, acc);
    check("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  task automatic random_run(input int k, input int ncyc);
    logic acc;
    for (int n = 0; n < ncyc; n++)
      cycle(k, 1'($urandom_range(0, 1)), rnd(), rnd(), rnd(),
            ($urandom_range(0, 3) != 0), acc);
    drain(k);
  endtask

  initial begin
    held = 1'b0;
    held_res = '0;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; arg_vld[i] = 1'b0; res_rdy[i] = 1'b0;
      a[i] = '0; b[i] = '0; c[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // Single triple through FORMULA 1: 2+3+4.
    do_reset(0);
    send(0, 32'd4, 32'd9, 32'd16, 1'b1);
    drain(0);

    // FORMULA 2 pair, order preserved.
    do_reset(1);
    send(1, 32'd6, 32'd5, 32'd16, 1'b1);
    send(1, 32'd0, 32'd0, 32'd0, 1'b1);
    drain(1);

    // Twenty back-to-back perfect squares; ring fills after four.
    do_reset(0);
    for (int i = 0; i < 20; i++) begin
      send(0, 32'(i * i), 32'd0, 32'd0, 1'b1);
      if (i == 3) check("full_after_4", 64'(arg_rdy[0]), 64'd0);
    end
    drain(0);

    // Consumer stalled for 200 cycles with the ring full.
    for (int i = 0; i < 4; i++) send(0, rnd(), rnd(), rnd(), 1'b0);
    idle(0, 200, 1'b0);
    check("stall_inflight", 64'(inflight[0]), 64'd4);
    check("stall_arg_rdy", 64'(arg_rdy[0]), 64'd0);
    drain(0);

    // Reset with three triples in flight; nothing stale may emerge.
    for (int i = 0; i < 3; i++) send(0, rnd(), rnd(), rnd(), 1'b0);
    idle(0, 10, 1'b0);
    do_reset(0);
    idle(0, 150, 1'b1);
    send(0, 32'd1, 32'd1, 32'd1, 1'b1);
    drain(0);

    // Randomised traffic against the reference model.
    random_run(1, 1000);
    do_reset(2);
    random_run(2, 1500);
    do_reset(3);
    random_run(3, 1500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
